// File: rtl/rr_arb_pkg.sv
// Shared types and default constants for the round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int N_REQ_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one search: the first asserted request at or after i_ptr,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_found,
    output logic [IW-1:0]    o_idx
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_found = |i_req;
        o_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N_REQ])
                o_idx = IW'((int'(i_ptr) + k) % N_REQ);
        end
    end

endmodule

// File: rtl/rr_arb_fsm.sv
// Round-robin arbiter FSM (IDLE -> GRANT -> RELEASE -> IDLE).
// Optional tenure limit: define RR_ARB_TIMEOUT_EN to force a release after
// TIMEOUT_CYC grant cycles; without it tenure is unlimited and timeout_err is 0.
module rr_arb_fsm
    import rr_arb_pkg::*;
#(
    parameter  int N_REQ       = N_REQ_DEF,
    parameter  int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int IW          = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_id,
    output logic             busy,
    output logic             win,
    output logic             timeout_err
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic            w_found;
    logic [IW-1:0]   w_idx;
    logic            w_take;
    logic            w_drop;
    logic            w_forced;
    logic            w_tmo;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0] r_cnt;

    // Tenure counter: cleared on grant, counts every cycle spent in GRANT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (w_take)
            r_cnt <= '0;
        else if (r_state == GRANT)
            r_cnt <= r_cnt + 1'b1;
    end

    assign w_tmo = (r_cnt == CW'(TIMEOUT_CYC - 1));
`else
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT_CYC > 0);
    assign w_tmo       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and Moore/Mealy outputs; non-owner requests are ignored
    // outside IDLE, so there is no preemption.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_drop      = 1'b0;
        w_forced    = 1'b0;
        busy        = 1'b0;
        win         = 1'b0;
        case (r_state)
            IDLE: begin
                win = |req;
                if (w_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                busy = 1'b1;
                if (!req[r_owner]) begin
                    w_drop      = 1'b1;
                    w_state_nxt = RELEASE;
                end else if (w_tmo) begin
                    w_drop      = 1'b1;
                    w_forced    = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                busy        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Owner, pointer and registered grant outputs; grant is cleared whenever
    // the next state is anything but GRANT, including recovery from bad codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            gnt         <= '0;
            gnt_id      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= w_forced;
            if (w_take) begin
                r_owner <= w_idx;
                gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << w_idx;
                gnt_id  <= w_idx;
            end else if (w_state_nxt != GRANT) begin
                gnt    <= '0;
                gnt_id <= '0;
            end
            if (w_drop)
                r_ptr <= (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arb_fsm.sv
// Self-checking bench for rr_arb_fsm: directed vectors plus a per-cycle
// comparison against a behavioural model of the arbitration rules.
module tb_rr_arb_fsm;

    localparam int N  = 4;
    localparam int TO = 4;
    localparam bit TMO_EN =
`ifdef RR_ARB_TIMEOUT_EN
        1'b1;
`else
        1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         win;
    logic         timeout_err;

    int n_chk = 0;
    int n_err = 0;

    rr_arb_fsm #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .win         (win),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the resource, whether a release cycle is in progress,
    // the rotation start point and how many cycles the owner has held it.
    int m_owner = -1;
    bit m_rel   = 1'b0;
    int m_ptr   = 0;
    int m_ten   = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_rel = 1'b0; m_ptr = 0; m_ten = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_rel) begin
                m_rel = 1'b0;
            end else if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_ptr = (m_owner + 1) % N; m_owner = -1; m_rel = 1'b1;
                end else if (TMO_EN && m_ten == TO) begin
                    m_ptr = (m_owner + 1) % N; m_owner = -1; m_rel = 1'b1; m_to = 1'b1;
                end else begin
                    m_ten++;
                end
            end else if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        break;
                    end
                end
                m_ten = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("gnt", gnt, e_gnt);
        chk("gnt_id", gnt_id, (m_owner >= 0) ? m_owner : 0);
        chk("busy", busy, (m_owner >= 0) || m_rel);
        chk("win", win, (m_owner < 0) && !m_rel && (req != '0));
        chk("timeout_err", timeout_err, m_to);
        chk("onehot", ($countones(gnt) <= 1), 1);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [N-1:0] exp_ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] g_val [$];
    int           g_cyc [$];
    int           on_cnt, pulses, first_run;
    bit           first_done;

    initial begin
        #1 rst = 1'b1;
        step(2);
        chk("rst_gnt", gnt, 0);
        chk("rst_id", gnt_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_to", timeout_err, 0);
        req = 4'b0001;
        #1 chk("rst_win_follows_req", win, 1);
        req = '0;
        rst = 1'b0;

        // Single requester: one-cycle latency, 5-cycle tenure, one RELEASE.
        step;
        req = 4'b0001;
        #1 chk("t1_idle_win", win, 1);
        step;
        chk("t1_gnt_latency", gnt, 4'b0001);
        chk("t1_win_in_grant", win, 0);
        step(4);
        chk("t1_gnt_held", gnt, 4'b0001);
        req = '0;
        step;
        chk("t1_release_gnt", gnt, 0);
        chk("t1_release_busy", busy, 1);
        step;
        chk("t1_idle_busy", busy, 0);
        req = 4'b0011;
        step;
        chk("t1_ptr_is_1", gnt, 4'b0010);
        req = '0;
        step(2);

        // All four requesting; each owner drops for its tenure cycle only.
        rst = 1'b1;
        step;
        rst = 1'b0;
        for (int c = 0; c < 13; c++) begin
            req = 4'b1111 & ~gnt;
            step;
            if (gnt != '0) begin
                g_val.push_back(gnt);
                g_cyc.push_back(c);
            end
        end
        chk("t2_ngrants", g_val.size(), 5);
        for (int i = 0; i < 5 && i < g_val.size(); i++)
            chk("t2_order", g_val[i], exp_ord[i]);
        for (int i = 1; i < g_cyc.size(); i++)
            chk("t2_spacing", g_cyc[i] - g_cyc[i-1], 3);
        req = '0;
        step(2);

        // Owner 3 wraps the pointer to 0; 0 beats 3 on the next request.
        req = 4'b1000;
        step;
        chk("t3_owner3", gnt, 4'b1000);
        req = '0;
        step;
        req = 4'b1001;
        step;
        chk("t3_idle_win", win, 1);
        step;
        chk("t3_wrap_to_0", gnt, 4'b0001);
        step;
        chk("t3_no_win_pending", win, 0);
        chk("t3_no_preempt", gnt, 4'b0001);
        req = 4'b1000;
        step(3);
        chk("t3_then_3", gnt, 4'b1000);
        req = '0;
        step(2);

        // Asynchronous reset mid-GRANT with owner 2.
        req = 4'b0100;
        step;
        chk("t4_owner2", gnt, 4'b0100);
        step;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t4_async_gnt", gnt, 0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_id", gnt_id, 0);
        chk("t4_async_to", timeout_err, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        req = 4'b0101;
        step;
        chk("t4_first_after_rst", gnt, 4'b0001);
        req = '0;
        step(2);

        // Requester 1 holds its request: tenure limited only with timeout.
        on_cnt = 0; pulses = 0; first_run = 0; first_done = 1'b0;
        req = 4'b0010;
        for (int c = 0; c < 14; c++) begin
            step;
            if (gnt[1]) on_cnt++;
            if (timeout_err) pulses++;
            if (gnt[1] && !first_done) first_run++;
            else if (first_run > 0) first_done = 1'b1;
        end
`ifdef RR_ARB_TIMEOUT_EN
        chk("t5_first_tenure", first_run, 4);
        chk("t5_pulses", pulses, 2);
        chk("t5_on_cycles", on_cnt, 10);
`else
        chk("t5_first_tenure", first_run, 14);
        chk("t5_pulses", pulses, 0);
        chk("t5_on_cycles", on_cnt, 14);
`endif
        req = '0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
